// File: rtl/iddr_align_pkg.sv
// Shared types and constants for the IDDR word-alignment controller.
package iddr_align_pkg;

  // Width of the bit-offset selector (supports WORD_W up to 16).
  localparam int unsigned SLIP_W = 4;

  // Alignment controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAILED = 2'd3
  } state_e;

endpackage

// File: rtl/iddr_gearbox.sv
// Pair-to-word gearbox: shifts {q1,q2} pairs into a 2*WORD_W history, tracks
// the word phase and extracts the candidate word at the selected bit offset.
// The boundary strobe and candidate are presented one cycle after the wrap,
// so the candidate already contains the pair shifted in on the wrap cycle.
module iddr_gearbox
  import iddr_align_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ce,
  input  logic              q1,
  input  logic              q2,
  input  logic [SLIP_W-1:0] slip_pos,
  output logic [WORD_W-1:0] cand_c,
  output logic              bnd_c
);

  localparam int unsigned HIST_W = 2 * WORD_W;
  localparam int unsigned PAIRS  = WORD_W / 2;
  localparam int unsigned PH_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PAIRS - 1);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              bnd_q, bnd_d;

  // Next history, phase and boundary; a clear wins over shifting.
  always_comb begin
    hist_d  = hist_q;
    phase_d = phase_q;
    bnd_d   = 1'b0;
    if (clr) begin
      hist_d  = '0;
      phase_d = '0;
    end else if (ce) begin
      hist_d  = {hist_q[HIST_W-3:0], q1, q2};
      bnd_d   = (phase_q == PH_LAST);
      phase_d = bnd_d ? '0 : phase_q + PH_W'(1);
    end
  end

  // Gearbox state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      phase_q <= '0;
      bnd_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      phase_q <= phase_d;
      bnd_q   <= bnd_d;
    end
  end

  assign cand_c = hist_q[slip_pos +: WORD_W];
  assign bnd_c  = bnd_q;

endmodule

// File: rtl/iddr_align_ctrl.sv
// IDDR word-alignment controller: searches bit offsets for a training word,
// locks after LOCK_CNT consecutive matches and then streams aligned words.
// Optional mismatch statistics output under IDDR_ALIGN_STATS_EN.
module iddr_align_ctrl
  import iddr_align_pkg::*;
#(
  parameter int unsigned       WORD_W    = 8,
  parameter logic [WORD_W-1:0] TRAIN_PAT = 8'hA5,
  parameter int unsigned       LOCK_CNT  = 4
) (
  input  logic              C,
  input  logic              R,
  input  logic              START,
  input  logic              Q1,
  input  logic              Q2,
  output logic              CE,
  output logic [WORD_W-1:0] WORD,
  output logic              WORD_VLD,
  output logic              LOCKED,
  output logic              FAIL,
  output logic [SLIP_W-1:0] SLIP_POS
`ifdef IDDR_ALIGN_STATS_EN
  ,
  output logic [7:0]        MISMATCH_CNT
`endif
);

  localparam logic [SLIP_W-1:0] SLIP_LAST  = SLIP_W'(WORD_W - 1);
  localparam logic [3:0]        MATCH_LAST = 4'(LOCK_CNT - 1);

  state_e            state_q, state_d;
  logic              ce_q, ce_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_vld_q, word_vld_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic [3:0]        match_q, match_d;
  logic              settle_q, settle_d;
`ifdef IDDR_ALIGN_STATS_EN
  logic [7:0]        mis_q, mis_d;
`endif

  logic [WORD_W-1:0] cand_c;
  logic              bnd_c;

  iddr_gearbox #(
    .WORD_W (WORD_W)
  ) u_gearbox (
    .clk      (C),
    .rst      (R),
    .clr      (START),
    .ce       (ce_q),
    .q1       (Q1),
    .q2       (Q2),
    .slip_pos (slip_q),
    .cand_c   (cand_c),
    .bnd_c    (bnd_c)
  );

  // Next-state and registered-output logic; START restarts from any state.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    slip_d     = slip_q;
    match_d    = match_q;
    settle_d   = settle_q;
`ifdef IDDR_ALIGN_STATS_EN
    mis_d      = mis_q;
`endif
    if (START) begin
      state_d  = ST_SEARCH;
      slip_d   = '0;
      match_d  = '0;
      settle_d = 1'b1;
`ifdef IDDR_ALIGN_STATS_EN
      mis_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (bnd_c) begin
            if (settle_q) begin
              settle_d = 1'b0;
            end else if (cand_c == TRAIN_PAT) begin
              if (match_q == MATCH_LAST) begin
                state_d = ST_LOCKED;
              end else begin
                match_d = match_q + 4'd1;
              end
            end else begin
              match_d = '0;
`ifdef IDDR_ALIGN_STATS_EN
              if (mis_q != 8'hFF) mis_d = mis_q + 8'd1;
`endif
              if (slip_q < SLIP_LAST) begin
                slip_d   = slip_q + SLIP_W'(1);
                settle_d = 1'b1;
              end else begin
                state_d = ST_FAILED;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (bnd_c) begin
            word_d     = cand_c;
            word_vld_d = 1'b1;
          end
        end
        ST_IDLE, ST_FAILED: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    ce_d     = (state_d == ST_SEARCH) || (state_d == ST_LOCKED);
    locked_d = (state_d == ST_LOCKED);
    fail_d   = (state_d == ST_FAILED);
  end

  // Controller registers with synchronous reset.
  always_ff @(posedge C) begin
    if (R) begin
      state_q    <= ST_IDLE;
      ce_q       <= 1'b0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      slip_q     <= '0;
      match_q    <= '0;
      settle_q   <= 1'b0;
`ifdef IDDR_ALIGN_STATS_EN
      mis_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ce_q       <= ce_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      slip_q     <= slip_d;
      match_q    <= match_d;
      settle_q   <= settle_d;
`ifdef IDDR_ALIGN_STATS_EN
      mis_q      <= mis_d;
`endif
    end
  end

  assign CE       = ce_q;
  assign WORD     = word_q;
  assign WORD_VLD = word_vld_q;
  assign LOCKED   = locked_q;
  assign FAIL     = fail_q;
  assign SLIP_POS = slip_q;
`ifdef IDDR_ALIGN_STATS_EN
  assign MISMATCH_CNT = mis_q;
`endif

endmodule

// File: tb/tb_iddr_align_ctrl.sv
// Directed bench for iddr_align_ctrl; the bench acts as the IDDR, producing
// a bit stream whose words end adv bits before each pair-group boundary
// (adv = expected SLIP_POS). Honours IDDR_ALIGN_STATS_EN.
module tb_iddr_align_ctrl;

  logic       C;
  logic       R;
  logic       START;
  logic       Q1;
  logic       Q2;
  logic       CE;
  logic [7:0] WORD;
  logic       WORD_VLD;
  logic       LOCKED;
  logic       FAIL;
  logic [3:0] SLIP_POS;
`ifdef IDDR_ALIGN_STATS_EN
  logic [7:0] MISMATCH_CNT;
`endif

  int checks   = 0;
  int failures = 0;

  int         n_bit;
  int         adv;
  int         chg_idx;
  logic [7:0] word_a;
  logic [7:0] word_b;
  logic       found;

  iddr_align_ctrl #(
    .WORD_W    (8),
    .TRAIN_PAT (8'hA5),
    .LOCK_CNT  (4)
  ) dut (
    .C        (C),
    .R        (R),
    .START    (START),
    .Q1       (Q1),
    .Q2       (Q2),
    .CE       (CE),
    .WORD     (WORD),
    .WORD_VLD (WORD_VLD),
    .LOCKED   (LOCKED),
    .FAIL     (FAIL),
    .SLIP_POS (SLIP_POS)
`ifdef IDDR_ALIGN_STATS_EN
    ,
    .MISMATCH_CNT (MISMATCH_CNT)
`endif
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Bit n of the transmitted stream, MSB of each word first.
  function automatic logic stream_bit(input int n);
    int         p;
    logic [7:0] w;
    p = n + adv;
    w = ((p / 8) >= chg_idx) ? word_b : word_a;
    return w[7 - (p % 8)];
  endfunction

  // One clock: present the next pair (only when the IDDR is enabled), then
  // sample 1 time unit after the rising edge.
  task automatic step();
    @(negedge C);
    if (R || START) begin
      Q1    = 1'b0;
      Q2    = 1'b0;
      n_bit = 0;
    end else if (CE) begin
      Q1    = stream_bit(n_bit);
      Q2    = stream_bit(n_bit + 1);
      n_bit = n_bit + 2;
    end
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mis(input string tag, input logic [7:0] exp);
`ifdef IDDR_ALIGN_STATS_EN
    chk(tag, 32'(MISMATCH_CNT), 32'(exp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    R = 1'b1; START = 1'b0; Q1 = 1'b0; Q2 = 1'b0;
    adv = 0; chg_idx = 1000; word_a = 8'hA5; word_b = 8'hA5; n_bit = 0;
    found = 1'b0;

    // Reset state
    step(); step();
    chk("rst_ce", 32'(CE), 0);
    chk("rst_locked", 32'(LOCKED), 0);
    chk("rst_fail", 32'(FAIL), 0);
    chk("rst_vld", 32'(WORD_VLD), 0);
    chk("rst_word", 32'(WORD), 0);
    chk("rst_slip", 32'(SLIP_POS), 0);
    chk_mis("rst_mis", 8'd0);
    R = 1'b0;
    step();
    chk("idle_ce", 32'(CE), 0);

    // Aligned A5: settle word + 4 matches -> lock 21 cycles after START
    START = 1'b1; step(); START = 1'b0;
    chk("s1_ce", 32'(CE), 1);
    repeat (20) step();
    chk("s1_prelock", 32'(LOCKED), 0);
    step();
    chk("s1_locked", 32'(LOCKED), 1);
    chk("s1_slip", 32'(SLIP_POS), 0);
    chk("s1_fail", 32'(FAIL), 0);
    chk_mis("s1_mis", 8'd0);
    // Next boundary 4 cycles later loads WORD and strobes for one cycle
    repeat (3) step();
    chk("s1_novld", 32'(WORD_VLD), 0);
    step();
    chk("s1_vld", 32'(WORD_VLD), 1);
    chk("s1_word", 32'(WORD), 32'h A5);
    step();
    chk("s1_vld_end", 32'(WORD_VLD), 0);
    chk("s1_word_hold", 32'(WORD), 32'h A5);

    // START in a LOCKED boundary cycle: restart wins, no strobe
    repeat (2) step();
    START = 1'b1; step(); START = 1'b0;
    chk("rs_locked", 32'(LOCKED), 0);
    chk("rs_vld", 32'(WORD_VLD), 0);
    chk("rs_ce", 32'(CE), 1);
    chk("rs_word_hold", 32'(WORD), 32'h A5);
    repeat (20) step();
    chk("rs_prelock", 32'(LOCKED), 0);
    step();
    chk("rs_relock", 32'(LOCKED), 1);

    // Offset-3 stream: reset mid-search once SLIP_POS reaches 2
    adv = 3;
    START = 1'b1; step(); START = 1'b0;
    repeat (8) step();
    chk("mr_settle_slip", 32'(SLIP_POS), 0);
    step();
    chk("mr_slip1", 32'(SLIP_POS), 1);
    repeat (8) step();
    chk("mr_slip2", 32'(SLIP_POS), 2);
    // R together with START: reset wins
    R = 1'b1; START = 1'b1; step(); R = 1'b0; START = 1'b0;
    chk("mr_ce", 32'(CE), 0);
    chk("mr_locked", 32'(LOCKED), 0);
    chk("mr_fail", 32'(FAIL), 0);
    chk("mr_vld", 32'(WORD_VLD), 0);
    chk("mr_word", 32'(WORD), 0);
    chk("mr_slip", 32'(SLIP_POS), 0);
    step();
    chk("mr_still_idle", 32'(CE), 0);
    adv = 0;
    START = 1'b1; step(); START = 1'b0;
    repeat (21) step();
    chk("mr_relock", 32'(LOCKED), 1);
    chk("mr_relock_slip", 32'(SLIP_POS), 0);

    // Offset-3 stream from LOCKED: offsets 0..2 mismatch, lock at 3
    adv = 3;
    START = 1'b1; step(); START = 1'b0;
    repeat (44) step();
    chk("d3_prelock", 32'(LOCKED), 0);
    chk("d3_preslip", 32'(SLIP_POS), 3);
    step();
    chk("d3_locked", 32'(LOCKED), 1);
    chk("d3_slip", 32'(SLIP_POS), 3);
    chk("d3_fail", 32'(FAIL), 0);
    chk_mis("d3_mis", 8'd3);
    // Switch the payload to 3C from the next stream word
    word_b  = 8'h3C;
    chg_idx = (n_bit + adv) / 8 + 1;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (WORD_VLD === 1'b1 && WORD === 8'h3C) found = 1'b1;
    end
    chk("d3_word_3c", 32'(found), 1);
    step();
    chk("d3_vld_end", 32'(WORD_VLD), 0);
    chk("d3_word_hold", 32'(WORD), 32'h3C);

    // Constant-zero stream: all 8 offsets fail
    word_a = 8'h00; word_b = 8'h00; adv = 0; chg_idx = 1000;
    START = 1'b1; step(); START = 1'b0;
    repeat (64) step();
    chk("f_prefail", 32'(FAIL), 0);
    chk("f_preslip", 32'(SLIP_POS), 7);
    chk("f_prece", 32'(CE), 1);
    step();
    chk("f_fail", 32'(FAIL), 1);
    chk("f_ce", 32'(CE), 0);
    chk("f_slip", 32'(SLIP_POS), 7);
    chk("f_locked", 32'(LOCKED), 0);
    chk_mis("f_mis", 8'd8);
    repeat (8) step();
    chk("f_hold_fail", 32'(FAIL), 1);
    chk("f_hold_slip", 32'(SLIP_POS), 7);
    chk("f_hold_vld", 32'(WORD_VLD), 0);
    START = 1'b1; step(); START = 1'b0;
    chk("f_restart_fail", 32'(FAIL), 0);
    chk("f_restart_ce", 32'(CE), 1);
    chk("f_restart_slip", 32'(SLIP_POS), 0);
    chk_mis("f_restart_mis", 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
